// File: rtl/handshake_mon_pkg.sv
// Shared types and helpers for the valid/ready handshake protocol monitor.
package handshake_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STALL     = 2'd1,
    TIMED_OUT = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DROP    = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam int BIT_DROP    = 0;
  localparam int BIT_DATA    = 1;
  localparam int BIT_TIMEOUT = 2;

  // Widest error vector: 32 channels x 3 kinds.
  localparam int MAX_ERR_W = 96;

  function automatic logic [6:0] popcount_err(input logic [MAX_ERR_W-1:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < MAX_ERR_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/handshake_mon_channel.sv
// One monitored valid/ready channel: stall FSM, payload latch, wait counter and
// combinational error/transfer strobes for the edge currently being sampled.
module handshake_mon_channel
  import handshake_mon_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic [2:0]        err_strobe,
  output logic              xfer,
  output logic [CNT_W-1:0]  stall_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  mon_state_t        state_r, state_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s, wait_inc_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              data_seen_r, data_seen_s;

  // Next-state, strobe and stall-length evaluation for the current sample.
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    data_s      = data_r;
    data_seen_s = data_seen_r;
    err_strobe  = 3'b000;
    xfer        = 1'b0;
    stall_len   = {CNT_W{1'b0}};
    wait_inc_s  = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + CNT_W'(1);
    if (!enable) begin
      state_s     = IDLE;
      wait_cnt_s  = {CNT_W{1'b0}};
      data_seen_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid && ready) begin
            xfer = 1'b1;
          end else if (valid) begin
            data_s      = data;
            wait_cnt_s  = CNT_W'(1);
            data_seen_s = 1'b0;
            // With a one-cycle timeout the very first stalled sample expires.
            if (TO_VAL == CNT_W'(1)) begin
              err_strobe[BIT_TIMEOUT] = 1'b1;
              state_s                 = TIMED_OUT;
            end else begin
              state_s = STALL;
            end
          end else begin
            state_s = IDLE;
          end
        end
        STALL, TIMED_OUT: begin
          if (!valid) begin
            err_strobe[BIT_DROP] = 1'b1;
            state_s              = IDLE;
            wait_cnt_s           = {CNT_W{1'b0}};
            data_seen_s          = 1'b0;
          end else begin
            if ((data != data_r) && !data_seen_r) begin
              err_strobe[BIT_DATA] = 1'b1;
              data_seen_s          = 1'b1;
            end else begin
              data_seen_s = data_seen_r;
            end
            if (ready) begin
              xfer        = 1'b1;
              stall_len   = wait_cnt_r;
              state_s     = IDLE;
              wait_cnt_s  = {CNT_W{1'b0}};
              data_seen_s = 1'b0;
            end else begin
              wait_cnt_s = wait_inc_s;
              if ((state_r == STALL) && (wait_inc_s == TO_VAL)) begin
                err_strobe[BIT_TIMEOUT] = 1'b1;
                state_s                 = TIMED_OUT;
              end else begin
                state_s = state_r;
              end
            end
          end
        end
        default: begin
          state_s     = IDLE;
          wait_cnt_s  = {CNT_W{1'b0}};
          data_seen_s = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= {CNT_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      data_seen_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      data_r      <= data_s;
      data_seen_r <= data_seen_s;
    end
  end

endmodule

// File: rtl/handshake_protocol_monitor.sv
// Multi-channel valid/ready protocol monitor: aggregates per-channel strobes into
// pulses, sticky flags, a saturating error count, first-error capture and max stall.
module handshake_protocol_monitor
  import handshake_mon_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 10,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH*3-1:0]      err_pulse,
  output logic [NUM_CH*3-1:0]      err_sticky,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_err_vld,
  output logic [CH_W-1:0]          first_err_ch,
  output logic [1:0]               first_err_code,
  output logic [CNT_W-1:0]         max_wait,
  output logic [CH_W-1:0]          max_wait_ch
);

  localparam int               NE      = NUM_CH * 3;
  localparam int               SUM_W   = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NE-1:0]    err_raw_s;
  logic [NUM_CH-1:0] xfer_s;
  logic [CNT_W-1:0] stall_len_s [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    handshake_mon_channel #(
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .valid     (valid[c]),
      .ready     (ready[c]),
      .data      (data[c*DATA_W +: DATA_W]),
      .err_strobe(err_raw_s[c*3 +: 3]),
      .xfer      (xfer_s[c]),
      .stall_len (stall_len_s[c])
    );
  end

  logic [NE-1:0]    err_pulse_r, err_sticky_r, sticky_s;
  logic [CNT_W-1:0] err_count_r, count_s, count_base_s;
  logic [SUM_W-1:0] sum_s;
  logic             fe_vld_r, fe_vld_s;
  logic [CH_W-1:0]  fe_ch_r, fe_ch_s;
  err_code_t        fe_code_r, fe_code_s;
  logic [CNT_W-1:0] max_wait_r, max_wait_s;
  logic [CH_W-1:0]  max_ch_r, max_ch_s;

  // Clear-then-record aggregation of this sample's strobes.
  always_comb begin
    count_base_s = clear ? {CNT_W{1'b0}} : err_count_r;
    sum_s        = SUM_W'(count_base_s) + SUM_W'(popcount_err(MAX_ERR_W'(err_raw_s)));
    count_s      = (sum_s > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_s[CNT_W-1:0];
    sticky_s     = (clear ? {NE{1'b0}} : err_sticky_r) | err_raw_s;
    fe_vld_s     = clear ? 1'b0 : fe_vld_r;
    fe_ch_s      = clear ? {CH_W{1'b0}} : fe_ch_r;
    fe_code_s    = clear ? ERR_NONE : fe_code_r;
    // Ascending scan of c*3+k gives lowest channel first, then lowest code.
    for (int i = 0; i < NE; i++) begin
      if (!fe_vld_s && err_raw_s[i]) begin
        fe_vld_s  = 1'b1;
        fe_ch_s   = CH_W'(i / 3);
        fe_code_s = err_code_t'(2'(i % 3 + 1));
      end else begin
        fe_vld_s = fe_vld_s;
      end
    end
    max_wait_s = clear ? {CNT_W{1'b0}} : max_wait_r;
    max_ch_s   = clear ? {CH_W{1'b0}} : max_ch_r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (xfer_s[c] && (stall_len_s[c] > max_wait_s)) begin
        max_wait_s = stall_len_s[c];
        max_ch_s   = CH_W'(c);
      end else begin
        max_wait_s = max_wait_s;
      end
    end
  end

  // Registered reporting outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_r  <= {NE{1'b0}};
      err_sticky_r <= {NE{1'b0}};
      err_count_r  <= {CNT_W{1'b0}};
      fe_vld_r     <= 1'b0;
      fe_ch_r      <= {CH_W{1'b0}};
      fe_code_r    <= ERR_NONE;
      max_wait_r   <= {CNT_W{1'b0}};
      max_ch_r     <= {CH_W{1'b0}};
    end else begin
      err_pulse_r  <= err_raw_s;
      err_sticky_r <= sticky_s;
      err_count_r  <= count_s;
      fe_vld_r     <= fe_vld_s;
      fe_ch_r      <= fe_ch_s;
      fe_code_r    <= fe_code_s;
      max_wait_r   <= max_wait_s;
      max_ch_r     <= max_ch_s;
    end
  end

  assign err_pulse      = err_pulse_r;
  assign err_sticky     = err_sticky_r;
  assign err_count      = err_count_r;
  assign first_err_vld  = fe_vld_r;
  assign first_err_ch   = fe_ch_r;
  assign first_err_code = fe_code_r;
  assign max_wait       = max_wait_r;
  assign max_wait_ch    = max_ch_r;

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Scoreboard bench: directed scenarios plus random traffic, checked against a
// transaction-level model of the monitoring rules.
module tb_handshake_protocol_monitor;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 10;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  valid = 4'h0;
  logic [3:0]  ready = 4'h0;
  logic [31:0] data = 32'h0;
  logic [11:0] err_pulse, err_sticky;
  logic [3:0]  err_count, max_wait;
  logic        first_err_vld;
  logic [1:0]  first_err_ch, first_err_code, max_wait_ch;

  always #5 clk = ~clk;

  handshake_protocol_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .valid(valid), .ready(ready), .data(data),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
    .first_err_code(first_err_code), .max_wait(max_wait), .max_wait_ch(max_wait_ch)
  );

  typedef struct packed {
    logic [11:0] pulse;
    logic [11:0] sticky;
    logic [3:0]  count;
    logic        fvld;
    logic [1:0]  fch;
    logic [1:0]  fcode;
    logic [3:0]  maxw;
    logic [1:0]  maxch;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: per-channel stall bookkeeping and global report.
  int          m_stalled [4];
  int          m_len     [4];
  int          m_derr    [4];
  int          m_tdone   [4];
  logic [7:0]  m_lat     [4];
  logic [11:0] m_sticky;
  int          m_count, m_fvld, m_fch, m_fcode, m_maxw, m_maxch;

  task automatic model_step(input bit r, input bit en, input bit clr,
                            input logic [3:0] v, input logic [3:0] rd,
                            input logic [31:0] d, output exp_t e);
    logic [11:0] p;
    logic [7:0]  dc;
    int          xlen [4];
    bit          xf   [4];
    p = 12'h000;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_stalled[c] = 0; m_len[c] = 0; m_derr[c] = 0; m_tdone[c] = 0; m_lat[c] = 8'h00;
      end
      m_sticky = 12'h000; m_count = 0; m_fvld = 0; m_fch = 0; m_fcode = 0;
      m_maxw = 0; m_maxch = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        xf[c] = 1'b0; xlen[c] = 0; dc = d[c*8 +: 8];
        if (!en) begin
          m_stalled[c] = 0;
        end else if (m_stalled[c] == 0) begin
          if (v[c] && rd[c]) begin
            xf[c] = 1'b1;
          end else if (v[c]) begin
            m_stalled[c] = 1; m_lat[c] = dc; m_len[c] = 1; m_derr[c] = 0; m_tdone[c] = 0;
            if (m_len[c] == TIMEOUT) begin p[c*3+2] = 1'b1; m_tdone[c] = 1; end
          end
        end else if (!v[c]) begin
          p[c*3] = 1'b1; m_stalled[c] = 0;
        end else begin
          if (dc != m_lat[c] && m_derr[c] == 0) begin p[c*3+1] = 1'b1; m_derr[c] = 1; end
          if (rd[c]) begin
            xf[c] = 1'b1; xlen[c] = (m_len[c] > CMAX) ? CMAX : m_len[c]; m_stalled[c] = 0;
          end else begin
            m_len[c]++;
            if (m_tdone[c] == 0 && m_len[c] == TIMEOUT) begin p[c*3+2] = 1'b1; m_tdone[c] = 1; end
          end
        end
      end
      if (clr) begin
        m_sticky = 12'h000; m_count = 0; m_fvld = 0; m_fch = 0; m_fcode = 0;
        m_maxw = 0; m_maxch = 0;
      end
      for (int c = 0; c < 4; c++) begin
        if (xf[c] && xlen[c] > m_maxw) begin m_maxw = xlen[c]; m_maxch = c; end
      end
      m_sticky = m_sticky | p;
      m_count  = m_count + $countones(p);
      if (m_count > CMAX) m_count = CMAX;
      for (int i = 0; i < 12; i++) begin
        if (m_fvld == 0 && p[i]) begin m_fvld = 1; m_fch = i / 3; m_fcode = i % 3 + 1; end
      end
    end
    e.pulse = p; e.sticky = m_sticky; e.count = 4'(m_count); e.fvld = (m_fvld != 0);
    e.fch = 2'(m_fch); e.fcode = 2'(m_fcode); e.maxw = 4'(m_maxw); e.maxch = 2'(m_maxch);
  endtask

  task automatic step(input bit r, input bit en, input bit clr,
                      input logic [3:0] v, input logic [3:0] rd, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; enable = en; clear = clr; valid = v; ready = rd; data = d;
    model_step(r, en, clr, v, rd, d, e);
    exp_q.push_back(e);
  endtask

  // Monitor: compares each registered result just after the sampling edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {err_pulse, err_sticky, err_count, first_err_vld, first_err_ch,
             first_err_code, max_wait, max_wait_ch};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d @%0t: got pulse=%h sticky=%h cnt=%0d fv=%b fch=%0d fcode=%0d maxw=%0d maxch=%0d; exp pulse=%h sticky=%h cnt=%0d fv=%b fch=%0d fcode=%0d maxw=%0d maxch=%0d",
                   n_vec, $time, a.pulse, a.sticky, a.count, a.fvld, a.fch, a.fcode, a.maxw, a.maxch,
                   e.pulse, e.sticky, e.count, e.fvld, e.fch, e.fcode, e.maxw, e.maxch);
        end
      end
    end
  end

  initial begin
    logic [31:0] rd_data;
    logic [3:0]  rv, rr;
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    // ch0: three stalled samples then accepted
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0000_0041);
    step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 32'h0000_0041);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    // ch2: timeout after 10 stalled samples, accepted at sample 14
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 32'h0055_0000);
    step(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0100, 32'h0055_0000);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    // ch1: payload changes twice during one stall
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 32'h0000_3000);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 32'h0000_3100);
    step(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 32'h0000_3200);
    step(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 32'h0000_3200);
    // ch3 DROP and ch1 DATA in the same sample, with clear
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000, 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010, 32'h0000_0700);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    // 20 DROP errors saturate the count, then clear with a simultaneous error
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0);
      step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 32'h0);
    // enable dropped, then reset, mid-stall
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0000_0011);
      step(k == 1, k == 1, 1'b0, 4'b0001, 4'b0000, 32'h0000_0011);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0000_0011);
      step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 32'h0000_0011);
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    // random traffic
    rd_data = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(15, 0) == 0) rd_data[c*8 +: 8] = 8'($urandom);
      end
      rv = ~4'($urandom & $urandom & $urandom);
      rr = 4'($urandom & $urandom);
      step($urandom_range(499, 0) == 0, $urandom_range(79, 0) != 0,
           $urandom_range(39, 0) == 0, rv, rr, rd_data);
    end
    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
